// File: rtl/load_store_unit.sv
// load_store_unit
//   Data-memory access stage between the ALU and the data memory. Accepts an
//   RV32I load/store (LB/LH/LW/LBU/LHU/SB/SH/SW), drives a req/gnt/rvalid
//   memory handshake, stalls the core while the access is in flight, and
//   returns sign/zero-extended load data. Illegal funct3, misaligned
//   addresses and bus timeouts complete with an error and a cause code.
//
// Ports
//   clk_i, rst_ni            clock (rising edge), async active-low reset
//   valid_i, we_i            op request (held while stall_o=1), 1=store
//   funct3_i, addr_i         RV32I size/sign field, effective address
//   wdata_i                  store data (rs2)
//   stall_o                  core must hold PC/operands
//   done_o                   one-cycle completion pulse
//   rdata_o                  extended load data (0 for stores / errors)
//   err_o, err_cause_o       error flag and cause (01 misaligned,
//                            10 timeout, 11 illegal funct3)
//   mem_req_o, mem_we_o      memory request / write
//   mem_addr_o, mem_be_o     word address, byte enables
//   mem_wdata_o              lane-replicated store data
//   mem_gnt_i, mem_rvalid_i  request accepted / response present
//   mem_rdata_i              load word
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [1:0]  err_cause_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  localparam logic [1:0]  CAUSE_NONE    = 2'b00;
  localparam logic [1:0]  CAUSE_MISALGN = 2'b01;
  localparam logic [1:0]  CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0]  CAUSE_ILLEGAL = 2'b11;
  // Last counter value before abort: the access gets TIMEOUT_CYCLES cycles
  // in REQ+WAIT, and the abort wins over a gnt/rvalid in that last cycle.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [1:0]  cause_q, cause_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    if (we) return (f3 != 3'b000) && (f3 != 3'b001) && (f3 != 3'b010);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lo;
      2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then extend by size/sign.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] word);
    logic [31:0] lane;
    lane = word >> {lo, 3'b000};
    case (f3)
      3'b000:  return {{24{lane[7]}}, lane[7:0]};
      3'b001:  return {{16{lane[15]}}, lane[15:0]};
      3'b100:  return {24'd0, lane[7:0]};
      3'b101:  return {16'd0, lane[15:0]};
      default: return lane;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    cause_d = cause_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          we_d    = we_i;
          f3_d    = funct3_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          rdata_d = 32'd0;
          err_d   = 1'b0;
          cause_d = CAUSE_NONE;
          if (is_illegal(we_i, funct3_i)) begin
            err_d   = 1'b1;
            cause_d = CAUSE_ILLEGAL;
            state_d = S_RESP;
          end else if (is_misaligned(funct3_i, addr_i[1:0])) begin
            err_d   = 1'b1;
            cause_d = CAUSE_MISALGN;
            state_d = S_RESP;
          end else begin
            cnt_d   = 16'd0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          cause_d = CAUSE_TIMEOUT;
          state_d = S_RESP;
        end else if (mem_gnt_i) begin
          // A same-cycle rvalid is ignored; the response is awaited in WAIT.
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          cause_d = CAUSE_TIMEOUT;
          state_d = S_RESP;
        end else if (mem_rvalid_i) begin
          rdata_d = we_q ? 32'd0 : load_extract(f3_q, addr_q[1:0], mem_rdata_i);
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      cause_q <= cause_d;
    end
  end

  // Operand/result registers carry no reset: every output that exposes them
  // is qualified by the control state.
  always_ff @(posedge clk_i) begin
    we_q    <= we_d;
    f3_q    <= f3_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  assign done_o      = (state_q == S_RESP);
  assign rdata_o     = done_o ? rdata_q : 32'd0;
  assign err_o       = done_o & err_q;
  assign err_cause_o = done_o ? cause_q : CAUSE_NONE;
  // rst_ni gates the combinational stall so it drops as soon as reset asserts.
  assign stall_o     = valid_i & ~done_o & rst_ni;

  assign mem_req_o   = (state_q == S_REQ);
  assign mem_we_o    = mem_req_o & we_q;
  assign mem_addr_o  = mem_req_o ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_be_o    = mem_req_o ? byte_en(f3_q, addr_q[1:0]) : 4'd0;
  assign mem_wdata_o = mem_req_o ? store_data(f3_q, wdata_q) : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic        we_i = 1'b0;
  logic [2:0]  funct3_i = 3'd0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wdata_i = 32'd0;
  logic        stall_o, done_o, err_o, mem_req_o, mem_we_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  logic [1:0]  err_cause_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'd0;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic [1:0]  cause;
  } exp_t;
  exp_t exp_q[$];

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .we_i(we_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
    .err_cause_o(err_cause_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: byte-lane arithmetic straight from the ISA rules.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rword,
                                output logic err, output logic [1:0] cause,
                                output logic [31:0] rd_exp, output logic [3:0] be,
                                output logic [31:0] wd);
    int nb, off;
    longint v;
    nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off = int'(addr[1:0]);
    err = 1'b0; cause = 2'd0; rd_exp = 32'd0; be = 4'd0; wd = 32'd0;
    if (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) begin
      err = 1'b1; cause = 2'd3;
    end else if (off % nb != 0) begin
      err = 1'b1; cause = 2'd1;
    end
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + nb) be[i] = 1'b1;
      wd[8*i +: 8] = wdata[8*(i % nb) +: 8];
    end
    if (!we && !err) begin
      v = longint'(rword >> (8 * off)) % (longint'(1) << (8 * nb));
      if (!f3[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
        v = v - (longint'(1) << (8 * nb));
      rd_exp = 32'(v);
    end
  endfunction

  // Monitor: every completion pops one expectation.
  always @(negedge clk_i) begin
    if (rst_ni && done_o) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_done: got done_o=1 expected no completion");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rdata", rdata_o, e.rd);
        chk("err", 32'(err_o), 32'(e.err));
        chk("cause", 32'(err_cause_o), 32'(e.cause));
      end
    end
  end

  // One access: gnt after gd REQ cycles, rvalid after rd WAIT cycles.
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rword,
                       input int gd, input int rd, input bit give_gnt, input bit give_rv);
    logic e_err; logic [1:0] e_cause; logic [31:0] e_rd, e_wd; logic [3:0] e_be;
    bit tmo, granted;
    int n, reqc, wc;
    exp_t e;
    model(we, f3, addr, wdata, rword, e_err, e_cause, e_rd, e_be, e_wd);
    tmo = !e_err && (!give_gnt || !give_rv || (gd + rd + 2 >= TO));
    e.rd = tmo ? 32'd0 : e_rd;
    e.err = e_err | tmo;
    e.cause = tmo ? 2'd2 : e_cause;
    exp_q.push_back(e);
    @(negedge clk_i);
    valid_i = 1'b1; we_i = we; funct3_i = f3; addr_i = addr; wdata_i = wdata;
    @(negedge clk_i);
    n = 0; reqc = 0; wc = 0; granted = 0;
    if (e_err) begin
      chk("err_no_req", 32'(mem_req_o), 32'd0);
    end else begin
      while (n < TO + 4 && !done_o) begin
        chk("stall_busy", 32'(stall_o), 32'd1);
        if (mem_req_o) begin
          if (reqc == 0) begin
            chk("mem_addr", mem_addr_o, {addr[31:2], 2'b00});
            chk("mem_be", 32'(mem_be_o), 32'(e_be));
            chk("mem_we", 32'(mem_we_o), 32'(we));
            if (we) chk("mem_wdata", mem_wdata_o, e_wd);
          end
          mem_gnt_i = give_gnt && (reqc == gd);
          if (mem_gnt_i) granted = 1;
          reqc++;
        end else if (granted) begin
          mem_rvalid_i = give_rv && (wc == rd);
          mem_rdata_i = rword;
          wc++;
        end
        @(negedge clk_i);
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        n++;
      end
      if (!give_gnt) chk("req_cycles", 32'(reqc), 32'(TO));
    end
    chk("done_seen", 32'(done_o), 32'd1);
    chk("stall_done", 32'(stall_o), 32'd0);
    valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    @(negedge clk_i); @(negedge clk_i);
    rst_ni = 1'b1;

    do_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2, 0, 1, 1);      // LW
    do_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFF7F, 0, 0, 1, 1);      // LB
    do_op(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFF7F, 1, 1, 1, 1);      // LBU
    do_op(1'b0, 3'b001, 32'h102, 32'h0, 32'h80FFFF7F, 0, 2, 1, 1);      // LH
    do_op(1'b1, 3'b001, 32'h206, 32'h1234ABCD, 32'h0, 0, 0, 1, 1);      // SH
    do_op(1'b1, 3'b000, 32'h207, 32'h000000A5, 32'h0, 1, 0, 1, 1);      // SB
    do_op(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, 1, 1);             // misaligned LW
    do_op(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 1, 1);             // illegal load
    do_op(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 0, 1, 1);             // illegal store
    do_op(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 0, 0, 0, 0);             // no gnt: timeout

    // A late rvalid after the timeout must not produce a completion.
    @(negedge clk_i);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55AA55AA;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    chk("late_rv_done", 32'(done_o), 32'd0);
    chk("late_rv_req", 32'(mem_req_o), 32'd0);
    @(negedge clk_i);
    chk("late_rv_done2", 32'(done_o), 32'd0);

    do_op(1'b0, 3'b010, 32'h404, 32'h0, 32'h0, 1, 0, 1, 0);             // timeout in WAIT

    // Reset while in WAIT.
    @(negedge clk_i);
    valid_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h300;
    @(negedge clk_i);
    chk("pre_rst_req", 32'(mem_req_o), 32'd1);
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    mem_gnt_i = 1'b0;
    chk("pre_rst_stall", 32'(stall_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("rst_wait_req", 32'(mem_req_o), 32'd0);
    chk("rst_wait_stall", 32'(stall_o), 32'd0);
    chk("rst_wait_done", 32'(done_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1; valid_i = 1'b0;
    do_op(1'b1, 3'b010, 32'h308, 32'hCAFEF00D, 32'h0, 0, 1, 1, 1);      // SW after reset

    for (int k = 0; k < 60; k++) begin
      logic [31:0] a;
      a = $urandom;
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, $urandom,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1, 1);
    end

    @(negedge clk_i); @(negedge clk_i);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
